// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index 0 is the rightmost entry; codes 10-15 render blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Binary-to-BCD (shift-and-add-3) converter with multiplexed 7-segment scanning.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 5,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  overflow,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int SCR_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [SCR_W-1:0]      scratch_q, scratch_d;
    logic [SCR_W-1:0]      adj;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  bcd_valid_q, bcd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  in_ready_q, in_ready_d;
    logic [CNT_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            digit_sel;
    logic [6:0]            seg_dec;
    logic                  lz_blank;
    logic                  ref_wrap;

    // Conversion FSM; bcd_q only changes in COMMIT so the display never shows partial results.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        bit_cnt_d   = bit_cnt_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        bcd_valid_d = 1'b0;
        adj         = scratch_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_d   = in_data;
                    scratch_d = '0;
                    bit_cnt_d = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                for (int i = 0; i <= DIGITS; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                bcd_d       = scratch_q[4*DIGITS-1:0];
                ovf_d       = (scratch_q[SCR_W-1 -: 4] != 4'd0);
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Scan path reads the next-cycle committed value so a commit and a wrap land together.
    always_comb begin
        ref_wrap  = (ref_cnt_q == CNT_W'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (ref_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        digit_sel = '0;
        lz_blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit_sel = bcd_d[4*i +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (i > 0 && (bcd_d >> (4*i)) == '0) lz_blank = 1'b1;
`endif
            end
        end
        an_d  = ~(DIGITS'(1) << idx_d);
        seg_d = ovf_d ? SEG_DASH : (lz_blank ? SEG_BLANK : seg_dec);
    end

    seg7_decode u_decode (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            bit_cnt_q   <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            an_q        <= ~DIGITS'(1);
            seg_q       <= SEG_TABLE[0];
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            bit_cnt_q   <= bit_cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bcd_out   = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign overflow  = ovf_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule
